mips_mc_ctrl: RTL

Control unit for the multi-cycle MIPS core, replacing the single-cycle combinational controller path. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction. It handshakes with a shared variable-latency instruction/data memory, guards each memory access with a parametrised timeout, and counts retired instructions.

---
 rtl/mips_mc_pkg.sv | 154 +++++++++++++++
 rtl/mips_mc_wait_timer.sv | 44 ++++
 rtl/mips_mc_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - state_t      : 4-bit FSM state encoding (FETCH = 0)
//   - OP_* / FN_*  : opcode and funct field constants understood by DECODE
//   - *_t enums    : encodings of the multiplexer / ALU select outputs
//   - ctrl_t       : bundle of every state-decoded control output
//   - decode_ctrl  : Moore output decoder, one entry per state
// -----------------------------------------------------------------------------
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXEC_I = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,  // ALU result (PC+4 during FETCH)
    PC_ALUOUT = 2'd1,  // branch target computed in DECODE
    PC_JUMP   = 2'd2,  // {PC[31:28], imm26, 2'b00}
    PC_REGA   = 2'd3   // readdata1, used by jr
  } pc_src_t;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2      // $31 for jal
  } reg_dst_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    B_REGB    = 2'd0,
    B_FOUR    = 2'd1,
    B_SEXT    = 2'd2,
    B_SEXT_SH = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  // fetch_wr marks the state whose ir_write/pc_write strobes are qualified
  // by mem_ready; every other field drives its output directly.
  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        fetch_wr;
    logic        pc_write;
    logic        pc_write_cond;
    pc_src_t     pc_src;
    reg_dst_t    reg_dst;
    mem_to_reg_t mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch_wr  = 1'b1;
        c.alu_src_b = B_FOUR;
      end
      S_DECODE: c.alu_src_b = B_SEXT_SH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = B_SEXT;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = WB_MDR;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = DST_RD;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = B_SEXT;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JUMP;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PC_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RA;
        c.mem_to_reg = WB_PC;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_REGA;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_wait_timer.sv
// -----------------------------------------------------------------------------
// mips_mc_wait_timer
// Counts cycles spent waiting on mem_ready in a memory state and flags the
// cycle whose edge would take the count to MEM_TIMEOUT.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : no wait is in progress this cycle (count returns to 0)
//   busy       : a memory state is waiting (mem_req=1, mem_ready=0)
//   expired    : this wait cycle is the MEM_TIMEOUT-th one; abort now
// MEM_TIMEOUT = 0 disables expiry. 2**TMR_W must exceed MEM_TIMEOUT.
// -----------------------------------------------------------------------------
module mips_mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam bit               ENABLE = (MEM_TIMEOUT > 0);
  localparam int               LAST_I = ENABLE ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0] LAST   = TMR_W'(LAST_I);

  logic [TMR_W-1:0] count_q;

  // count_q holds the number of wait cycles already completed, so the
  // access aborts at the edge that would bring it to MEM_TIMEOUT.
  assign expired = ENABLE && busy && (count_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || expired) begin
      count_q <= '0;
    end else if (busy) begin
      count_q <= count_q + TMR_W'(1);
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Moore control FSM for the multi-cycle MIPS core: FETCH, DECODE, then the
// execute / memory / writeback states for each instruction class.
//   clk, rst_n                 : clock, synchronous active-low reset
//   opcode, funct, zero        : instruction fields and ALU zero flag
//   mem_ready                  : memory completes the current access
//   mem_req, mem_we, iord      : memory handshake and address select
//   ir_write, pc_write,
//   pc_write_cond, pc_src      : IR / PC update controls
//   reg_dst, mem_to_reg,
//   reg_write                  : register-file write controls
//   alu_src_a, alu_src_b,
//   alu_op                     : ALU operand / operation selects
//   state                      : current FSM state (debug)
//   retired                    : retired-instruction count, wraps
//   illegal_op, mem_err        : sticky error flags
// Outputs come from registers loaded with the decode of the next state, so
// they always reflect state alone. The one exception is the FETCH pair
// ir_write/pc_write, qualified by mem_ready so IR and PC+4 load together.
// -----------------------------------------------------------------------------
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_op,
  output logic             mem_err
);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q, mem_err_q;
  logic             retire, set_illegal, set_mem_err;
  logic             busy, tmr_expired;

  // The branch decision is taken in the datapath from pc_write_cond & zero;
  // the controller itself never looks at the flag.
  logic unused;
  assign unused = zero;

  // mem_req is high exactly in the three wait states, so it doubles as the
  // "waiting" qualifier; mem_ready with mem_req low is thereby ignored.
  assign busy = ctrl_q.mem_req && !mem_ready;

  mips_mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!busy),
    .busy   (busy),
    .expired(tmr_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          state_d     = S_FETCH;
          set_mem_err = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default: begin
            // PC was already advanced in FETCH, so the word acts as a NOP.
            state_d     = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (tmr_expired) begin
          state_d     = S_FETCH;
          set_mem_err = 1'b1;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (tmr_expired) begin
          state_d     = S_FETCH;
          set_mem_err = 1'b1;
        end
      end
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH);
      retired_q <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      if (retire)      retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_mem_err) mem_err_q <= 1'b1;
    end
  end

  assign mem_req       = ctrl_q.mem_req;
  assign mem_we        = ctrl_q.mem_we;
  assign iord          = ctrl_q.iord;
  assign ir_write      = ctrl_q.fetch_wr && mem_ready;
  assign pc_write      = ctrl_q.pc_write || (ctrl_q.fetch_wr && mem_ready);
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign pc_src        = ctrl_q.pc_src;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign state         = state_q;
  assign retired       = retired_q;
  assign illegal_op    = illegal_q;
  assign mem_err       = mem_err_q;

endmodule
